// File: rtl/pool_seq_ctrl.sv
// pool_seq_ctrl: runs one pooling job. Streams source rows into the pool
// block, writes every pooled row to the destination buffer, then pulses done.
// Optional drain watchdog: define POOL_SEQ_TIMEOUT_EN to build it.
//
// Handshake: all strobes are single-cycle qualifiers with no back-pressure.
// src_rd_en is a read request, answered by src_rd_data exactly one cycle
// later. pool_in_valid / pool_out_valid qualify their data buses in the same
// cycle. dst_wr_en qualifies dst_wr_addr/dst_wr_data in the same cycle.
module pool_seq_ctrl #(
  parameter int DWIDTH        = 8,
  parameter int DESIGN_SIZE   = 16,
  parameter int MASK_WIDTH    = 16,
  parameter int MAX_BITS_POOL = 3,
  parameter int AWIDTH        = 10,
  parameter int TIMEOUT       = 64
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic [MAX_BITS_POOL-1:0]        cfg_window,
  input  logic                            cfg_bypass,
  input  logic [AWIDTH-1:0]               cfg_num_rows,
  input  logic [AWIDTH-1:0]               cfg_src_base,
  input  logic [AWIDTH-1:0]               cfg_dst_base,
  input  logic [MASK_WIDTH-1:0]           cfg_mask,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            src_rd_en,
  output logic [AWIDTH-1:0]               src_rd_addr,
  input  logic [DESIGN_SIZE*DWIDTH-1:0]   src_rd_data,
  output logic                            pool_enable,
  output logic                            pool_in_valid,
  output logic [MAX_BITS_POOL-1:0]        pool_window,
  output logic [MASK_WIDTH-1:0]           pool_mask,
  output logic [DESIGN_SIZE*DWIDTH-1:0]   pool_inp_data,
  input  logic                            pool_out_valid,
  input  logic [DESIGN_SIZE*DWIDTH-1:0]   pool_out_data,
  output logic                            dst_wr_en,
  output logic [AWIDTH-1:0]               dst_wr_addr,
  output logic [DESIGN_SIZE*DWIDTH-1:0]   dst_wr_data,
  output logic [2:0]                      dbg_state
);

  localparam int DW = DESIGN_SIZE * DWIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [MAX_BITS_POOL-1:0] window_q;
  logic                     bypass_q;
  logic [AWIDTH-1:0]        num_rows_q;
  logic [AWIDTH-1:0]        src_base_q;
  logic [AWIDTH-1:0]        dst_base_q;
  logic [MASK_WIDTH-1:0]    mask_q;
  logic [AWIDTH-1:0]        rd_cnt;
  logic [AWIDTH-1:0]        out_cnt;
  logic [AWIDTH-1:0]        exp_cnt;
  logic                     in_valid_q;
  logic                     wr_en_q;
  logic [AWIDTH-1:0]        wr_addr_q;
  logic [DW-1:0]            wr_data_q;
  logic                     err_q;
  logic                     job_active;
  logic                     cfg_bad;
  logic                     last_rd;
  logic                     accept_out;
  logic                     drop_out;
  logic                     wd_expired;

  // Configuration checks and expected output count, all from latched config
  always_comb begin
    cfg_bad = !((window_q == MAX_BITS_POOL'(1)) || (window_q == MAX_BITS_POOL'(2)) ||
                (window_q == MAX_BITS_POOL'(4)));
    if (!bypass_q) begin
      if ((window_q == MAX_BITS_POOL'(2)) && num_rows_q[0]) cfg_bad = 1'b1;
      if ((window_q == MAX_BITS_POOL'(4)) && (|num_rows_q[1:0])) cfg_bad = 1'b1;
    end
    exp_cnt = num_rows_q;
    if (!bypass_q) begin
      if (window_q == MAX_BITS_POOL'(4))      exp_cnt = num_rows_q >> 2;
      else if (window_q == MAX_BITS_POOL'(2)) exp_cnt = num_rows_q >> 1;
    end
  end

  assign job_active = (state == S_CHECK) || (state == S_READ) || (state == S_DRAIN);
  assign last_rd    = (state == S_READ) && (rd_cnt == num_rows_q - AWIDTH'(1));
  assign accept_out = job_active && pool_out_valid && (out_cnt < exp_cnt);
  assign drop_out   = job_active && pool_out_valid && !(out_cnt < exp_cnt);

`ifdef POOL_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expired = (state == S_DRAIN) && !pool_out_valid &&
                      (wd_cnt == WD_W'(TIMEOUT - 1));

  // Watchdog: consecutive DRAIN cycles without a pool output
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wd_cnt <= '0;
    else if ((state != S_DRAIN) || pool_out_valid) wd_cnt <= '0;
    else wd_cnt <= wd_cnt + WD_W'(1);
  end
`else
  assign wd_expired = 1'b0;
  // TIMEOUT only has meaning when the watchdog is built
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CHECK;
      S_CHECK: begin
        if (cfg_bad || (num_rows_q == '0)) state_nx = S_FIN;
        else                               state_nx = S_READ;
      end
      S_READ:  if (last_rd) state_nx = S_DRAIN;
      S_DRAIN: begin
        if (out_cnt == exp_cnt) state_nx = S_FIN;
        else if (wd_expired)    state_nx = S_FIN;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Config latch, counters, error flag and registered write port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      window_q   <= '0;
      bypass_q   <= 1'b0;
      num_rows_q <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      mask_q     <= '0;
      rd_cnt     <= '0;
      out_cnt    <= '0;
      in_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      in_valid_q <= (state == S_READ);
      wr_en_q    <= accept_out;
      if ((state == S_IDLE) && start) begin
        window_q   <= cfg_window;
        bypass_q   <= cfg_bypass;
        num_rows_q <= cfg_num_rows;
        src_base_q <= cfg_src_base;
        dst_base_q <= cfg_dst_base;
        mask_q     <= cfg_mask;
        rd_cnt     <= '0;
        out_cnt    <= '0;
        err_q      <= 1'b0;
      end
      if (state == S_READ) rd_cnt <= rd_cnt + AWIDTH'(1);
      if (accept_out) begin
        wr_addr_q <= dst_base_q + out_cnt;
        wr_data_q <= pool_out_data;
        out_cnt   <= out_cnt + AWIDTH'(1);
      end
      if (((state == S_CHECK) && cfg_bad) || drop_out || wd_expired) err_q <= 1'b1;
    end
  end

  assign busy          = job_active;
  assign done          = (state == S_FIN);
  assign err           = err_q;
  assign src_rd_en     = (state == S_READ);
  assign src_rd_addr   = (state == S_READ) ? (src_base_q + rd_cnt) : '0;
  assign pool_enable   = job_active && !bypass_q;
  assign pool_in_valid = in_valid_q;
  assign pool_window   = job_active ? window_q : '0;
  assign pool_mask     = job_active ? mask_q : '0;
  assign pool_inp_data = in_valid_q ? src_rd_data : '0;
  assign dst_wr_en     = wr_en_q;
  assign dst_wr_addr   = wr_addr_q;
  assign dst_wr_data   = wr_data_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Directed bench for pool_seq_ctrl with a behavioural pool block and source
// buffer. Each task runs one scenario and checks its results inline.
module tb_pool_seq_ctrl;

  localparam int DWIDTH = 8;
  localparam int DESIGN_SIZE = 16;
  localparam int MASK_WIDTH = 16;
  localparam int MAX_BITS_POOL = 3;
  localparam int AWIDTH = 10;
  localparam int DW = DESIGN_SIZE * DWIDTH;

  logic clk = 1'b0;
  logic resetn, start, cfg_bypass;
  logic [MAX_BITS_POOL-1:0] cfg_window;
  logic [AWIDTH-1:0] cfg_num_rows, cfg_src_base, cfg_dst_base;
  logic [MASK_WIDTH-1:0] cfg_mask;
  logic busy, done, err, src_rd_en, pool_enable, pool_in_valid, dst_wr_en;
  logic [AWIDTH-1:0] src_rd_addr, dst_wr_addr;
  logic [DW-1:0] src_rd_data, pool_inp_data, pool_out_data, dst_wr_data;
  logic [MAX_BITS_POOL-1:0] pool_window;
  logic [MASK_WIDTH-1:0] pool_mask;
  logic pool_out_valid;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  pool_seq_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start),
    .cfg_window(cfg_window), .cfg_bypass(cfg_bypass), .cfg_num_rows(cfg_num_rows),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_mask(cfg_mask),
    .busy(busy), .done(done), .err(err),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .pool_enable(pool_enable), .pool_in_valid(pool_in_valid), .pool_window(pool_window),
    .pool_mask(pool_mask), .pool_inp_data(pool_inp_data),
    .pool_out_valid(pool_out_valid), .pool_out_data(pool_out_data),
    .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // source buffer: data one cycle after the read strobe
  logic [DW-1:0] src_mem [0:1023];
  initial src_rd_data = '0;
  always @(posedge clk) if (src_rd_en) src_rd_data <= src_mem[src_rd_addr];

  function automatic logic [DW-1:0] row_val(input int a);
    return {8{16'(a * 37 + 5)}};
  endfunction

  // pool model: one output per model_win inputs, carrying the last input,
  // one cycle later; at most model_limit outputs per job
  int model_win = 1;
  int model_limit = 1000;
  int model_grp;
  int model_emitted;
  logic clr = 1'b0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pool_out_valid <= 1'b0;
      pool_out_data  <= '0;
      model_grp      <= 0;
      model_emitted  <= 0;
    end else begin
      pool_out_valid <= 1'b0;
      if (clr) begin
        model_grp     <= 0;
        model_emitted <= 0;
      end else if (pool_in_valid) begin
        if (model_grp + 1 >= model_win) begin
          model_grp <= 0;
          if (model_emitted < model_limit) begin
            pool_out_valid <= 1'b1;
            pool_out_data  <= pool_inp_data;
            model_emitted  <= model_emitted + 1;
          end
        end else begin
          model_grp <= model_grp + 1;
        end
      end
    end
  end

  // monitor: records reads, writes, done pulses and held-config violations
  logic [AWIDTH-1:0] rd_addrs[$];
  int rd_cycs[$];
  logic [AWIDTH-1:0] wr_addrs[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_datas[$];
  int done_cnt, win_bad, en_bad, cyc;
  logic [MAX_BITS_POOL-1:0] exp_window;
  logic exp_enable;
  initial begin
    cyc = 0; done_cnt = 0; win_bad = 0; en_bad = 0;
  end
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      rd_addrs.delete(); rd_cycs.delete(); wr_addrs.delete(); wr_datas.delete();
      done_cnt <= 0; win_bad <= 0; en_bad <= 0;
    end else begin
      if (src_rd_en) begin rd_addrs.push_back(src_rd_addr); rd_cycs.push_back(cyc); end
      if (dst_wr_en) begin wr_addrs.push_back(dst_wr_addr); wr_datas.push_back(dst_wr_data); end
      if (done) done_cnt <= done_cnt + 1;
      if (busy && (pool_window !== exp_window)) win_bad <= win_bad + 1;
      if (busy && (pool_enable !== exp_enable)) en_bad <= en_bad + 1;
    end
  end

  // driver: configure, pulse start, run until done plus 20 idle cycles
  task automatic setup_job(input logic byp, input int win, input int rows, input int src,
                           input int dst, input int mwin, input int mlimit);
    cfg_bypass = byp; cfg_window = 3'(win); cfg_num_rows = 10'(rows);
    cfg_src_base = 10'(src); cfg_dst_base = 10'(dst); cfg_mask = 16'hA5C3;
    exp_window = 3'(win); exp_enable = !byp;
    model_win = mwin; model_limit = mlimit;
    clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    clr = 1'b0; start = 1'b1;
  endtask

  task automatic run_job(input logic byp, input int win, input int rows, input int src,
                         input int dst, input int mwin, input int mlimit,
                         input int restart_at, input int budget, output int done_at);
    setup_job(byp, win, rows, src, dst, mwin, mlimit);
    done_at = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start = (c == restart_at);
      @(negedge clk);
      if (done && done_at < 0) done_at = c;
      if (done_at >= 0 && c >= done_at + 20) break;
    end
    start = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, err, src_rd_en, pool_enable, pool_in_valid, dst_wr_en} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {busy, done, err, src_rd_en, pool_enable, pool_in_valid, dst_wr_en});
    end
    checks++;
    if ({src_rd_addr, dst_wr_addr, pool_window, pool_mask} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got %h expected 0", {src_rd_addr, dst_wr_addr, pool_window, pool_mask});
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
  endtask

  task automatic test_bypass();
    int d;
    run_job(1'b1, 1, 16, 0, 32, 1, 1000, 0, 200, d);
    check_int("bypass_done_seen", int'(d > 0), 1);
    check_int("bypass_done_cnt", done_cnt, 1);
    check_int("bypass_err", int'(err), 0);
    check_int("bypass_reads", rd_addrs.size(), 16);
    check_int("bypass_writes", wr_addrs.size(), 16);
    check_int("bypass_enable", en_bad, 0);
    for (int i = 0; i < 16 && i < wr_addrs.size(); i++) begin
      check_int("bypass_rd_addr", int'(rd_addrs[i]), i);
      check_int("bypass_wr_addr", int'(wr_addrs[i]), 32 + i);
      checks++;
      if (wr_datas[i] !== row_val(i)) begin
        errors++;
        $display("FAIL bypass_wr_data[%0d]: got %h expected %h", i, wr_datas[i], row_val(i));
      end
    end
  endtask

  task automatic test_window2();
    int d;
    for (int i = 0; i < 16; i++) src_mem[100 + i] = {8{16'(i)}};
    exp_q.delete();
    for (int j = 0; j < 8; j++) exp_q.push_back({8{16'(2 * j + 1)}});
    run_job(1'b0, 2, 16, 100, 200, 2, 1000, 0, 200, d);
    check_int("win2_done_cnt", done_cnt, 1);
    check_int("win2_err", int'(err), 0);
    check_int("win2_reads", rd_addrs.size(), 16);
    if (rd_cycs.size() == 16) check_int("win2_read_span", rd_cycs[15] - rd_cycs[0], 15);
    check_int("win2_window_held", win_bad, 0);
    check_int("win2_enable_held", en_bad, 0);
    check_int("win2_writes", wr_addrs.size(), 8);
    for (int j = 0; j < 8 && j < wr_addrs.size(); j++) begin
      check_int("win2_wr_addr", int'(wr_addrs[j]), 200 + j);
      checks++;
      if (wr_datas[j] !== exp_q[j]) begin
        errors++;
        $display("FAIL win2_wr_data[%0d]: got %h expected %h", j, wr_datas[j], exp_q[j]);
      end
    end
    for (int i = 0; i < 16; i++) src_mem[100 + i] = row_val(100 + i);
  endtask

  task automatic test_bad_cfg();
    int d;
    // window 3; a start in the FIN cycle must be ignored
    run_job(1'b0, 3, 8, 0, 0, 1, 1000, 2, 100, d);
    check_int("win3_done_at", d, 2);
    check_int("win3_done_cnt", done_cnt, 1);
    check_int("win3_err", int'(err), 1);
    check_int("win3_reads", rd_addrs.size(), 0);
    check_int("win3_writes", wr_addrs.size(), 0);
    run_job(1'b0, 4, 6, 0, 0, 4, 1000, 0, 100, d);
    check_int("rows6_done_at", d, 2);
    check_int("rows6_err", int'(err), 1);
    check_int("rows6_reads", rd_addrs.size(), 0);
    check_int("rows6_writes", wr_addrs.size(), 0);
  endtask

  task automatic test_zero_rows();
    int d;
    run_job(1'b0, 1, 0, 0, 0, 1, 1000, 0, 100, d);
    check_int("zero_done_at", d, 2);
    check_int("zero_err_cleared", int'(err), 0);
    check_int("zero_reads", rd_addrs.size(), 0);
    check_int("zero_writes", wr_addrs.size(), 0);
  endtask

  task automatic test_wrap();
    int d;
    run_job(1'b1, 1, 8, 1020, 1022, 1, 1000, 0, 200, d);
    check_int("wrap_done_cnt", done_cnt, 1);
    check_int("wrap_reads", rd_addrs.size(), 8);
    check_int("wrap_writes", wr_addrs.size(), 8);
    for (int i = 0; i < 8 && i < rd_addrs.size() && i < wr_addrs.size(); i++) begin
      check_int("wrap_rd_addr", int'(rd_addrs[i]), (1020 + i) % 1024);
      check_int("wrap_wr_addr", int'(wr_addrs[i]), (1022 + i) % 1024);
      checks++;
      if (wr_datas[i] !== row_val((1020 + i) % 1024)) begin
        errors++;
        $display("FAIL wrap_wr_data[%0d]: got %h expected %h", i, wr_datas[i],
                 row_val((1020 + i) % 1024));
      end
    end
  endtask

  task automatic test_drop_extra();
    int d;
    // pool emits every input although the job expects one per pair
    run_job(1'b0, 2, 4, 0, 0, 1, 1000, 0, 100, d);
    check_int("drop_done_cnt", done_cnt, 1);
    check_int("drop_err", int'(err), 1);
    check_int("drop_writes", wr_addrs.size(), 2);
    if (wr_datas.size() == 2) begin
      checks++;
      if (wr_datas[1] !== row_val(1)) begin
        errors++;
        $display("FAIL drop_wr_data: got %h expected %h", wr_datas[1], row_val(1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int d;
    setup_job(1'b1, 1, 16, 0, 0, 1, 1000);
    repeat (4) begin @(posedge clk); #1; start = 1'b0; end
    check_int("mid_in_read", int'(src_rd_en), 1);
    resetn = 1'b0;
    @(negedge clk);
    check_int("mid_ctrl_zero", int'({busy, done, err, src_rd_en, pool_enable, pool_in_valid, dst_wr_en}), 0);
    check_int("mid_addr_zero", int'(src_rd_addr), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    // clean job with a start pulse while busy
    run_job(1'b0, 4, 8, 500, 10, 4, 1000, 4, 200, d);
    check_int("clean_done_cnt", done_cnt, 1);
    check_int("clean_err", int'(err), 0);
    check_int("clean_reads", rd_addrs.size(), 8);
    check_int("clean_writes", wr_addrs.size(), 2);
    if (wr_addrs.size() == 2) begin
      check_int("clean_wr_addr1", int'(wr_addrs[1]), 11);
      checks++;
      if (wr_datas[0] !== row_val(503) || wr_datas[1] !== row_val(507)) begin
        errors++;
        $display("FAIL clean_wr_data: got %h %h expected %h %h", wr_datas[0], wr_datas[1],
                 row_val(503), row_val(507));
      end
    end
  endtask

  task automatic test_starved_drain();
    int d;
    run_job(1'b0, 2, 8, 0, 0, 2, 3, 0, 150, d);
    check_int("starve_writes", wr_addrs.size(), 3);
`ifdef POOL_SEQ_TIMEOUT_EN
    check_int("starve_done_seen", int'(d > 0), 1);
    check_int("starve_err", int'(err), 1);
`else
    check_int("starve_no_done", d, -1);
    check_int("starve_busy", int'(busy), 1);
`endif
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check_int("starve_recover", int'(busy), 0);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) src_mem[a] = row_val(a);
    resetn = 1'b0; start = 1'b0; cfg_bypass = 1'b0; cfg_window = '0;
    cfg_num_rows = '0; cfg_src_base = '0; cfg_dst_base = '0; cfg_mask = '0;
    exp_window = '0; exp_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_bypass();
    test_window2();
    test_bad_cfg();
    test_zero_rows();
    test_wrap();
    test_drop_extra();
    test_reset_mid();
    test_starved_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
